chain_score_sched: RTL and testbench
====================================

// Module: chain_score_sched
// PURPOSE
//  Sequences the pipelined chaining-score engine (computeScorepp) for anchor chaining DP.
//  Per incoming anchor i: issue up to N predecessor pairs (j=i-1 down to i-N), one per cycle.
//  Track each issued pair through the engine's fixed latency and fold results into f(i)=max(w_i, f(j)+score).
//  Emit f(i) and its best predecessor. Sits between the anchor stream and the chain backtrack logic.
// PARAMETERS
//  N          16  predecessor window depth; power of two, >=2
//  SCORE_LAT   9  cycles from engine sampling sc_* to matching sc_result
//  IDX_W      16  anchor index width
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-low (asserted at 0)
//  in_valid      in   1      anchor offered
//  in_ready      out  1      anchor accepted when in_valid&in_ready
//  in_first      in   1      anchor starts a new read: window cleared, index restarts at 0
//  in_r/in_q     in   32     reference / query position, unsigned
//  in_w          in   32     anchor span weight, unsigned
//  cfg_w_avg     in   32     forwarded to engine W_avg, static during operation
//  cfg_max_dist  in   32     max allowed r_i-r_j, static
//  sc_riX/sc_riY out  32     r_i / r_j to engine
//  sc_qiX/sc_qiY out  32     q_i / q_j to engine
//  sc_W/sc_W_avg out  32     w_i / cfg_w_avg to engine
//  sc_result     in   32     engine score, two's complement
//  out_valid     out  1      result valid
//  out_ready     in   1      consumer accepts
//  out_f         out  32     f(i), signed
//  out_pred      out  IDX_W  best predecessor index; all-ones = none
//  out_idx       out  IDX_W  index of anchor i
// BEHAVIOUR
//  Reset: all outputs 0, except in_ready=0. Window count=0, index=0, tag pipe cleared, state IDLE.
//  FSM IDLE->ISSUE->DRAIN->EMIT->IDLE. in_ready=1 only in IDLE.
//  IDLE: accept on in_valid. Latch r,q,w,idx. If in_first: count=0, idx=0.
//    best=w_i, pred=all-ones. Go ISSUE if count>0, else EMIT.
//  ISSUE: one pair per cycle, j from newest to oldest, min(count,N) pairs.
//    sc_* registered; they hold their last value when not issuing.
//    Pair valid iff r_i>r_j && q_i>q_j && (r_i-r_j)<=cfg_max_dist.
//    Invalid pairs are still issued but tagged invalid. Last issue -> DRAIN.
//  Tag pipe: SCORE_LAT-deep shift of {valid,live,slot}. At the output, if live&valid:
//    cand=f_j+sc_result (32b wrap, no saturation).
//    If cand>best (signed, strict): best=cand, pred=idx_j. Strict compare: ties keep nearer predecessor.
//  DRAIN: wait until no live tag remains -> EMIT.
//    Latency per anchor = 1 + npairs + SCORE_LAT + 1 cycles to out_valid.
//  EMIT: out_valid=1; outputs stable until out_ready.
//    On handshake: write {r,q,best,idx} to circular slot wp; wp++ mod N; count=min(count+1,N); idx++ -> IDLE.
//  Window wrap: oldest entry overwritten once count==N. idx wraps mod 2^IDX_W.
//  in_first mid-stream acts only at acceptance; it never aborts work in flight.
//  Reset mid-operation: immediate abandon; no partial result emitted.
// STRUCTURE
//  Shared package: IDX_NONE (all-ones), FSM state encodings, score width 32.
//  Sub-module: chain_tag_pipe (SCORE_LAT-deep valid/live/slot delay line, async active-low reset).
//  Window is a register array (N x 4 fields). The engine is instantiated by the parent, not here.
// TESTING (bench engine model: fixed SCORE_LAT delay, programmable return value)
//  1. in_first, r=100 q=50 w=15 -> out_f=15, out_pred=FFFF, out_idx=0; no sc issue.
//  2. Then r=110 q=60 w=15, engine returns 10 -> one issue (riX=110, riY=100); out_f=25, out_pred=0, idx=1.
//  3. Then r=90 q=70 w=15 (r_j>=r_i) -> pairs tagged invalid; out_f=15, out_pred=FFFF.
//  4. Stream N+3 rising anchors, engine returns 1 -> anchor N+2 issues exactly N pairs; window wraps correctly.
//  5. Two predecessors give equal cand=40 -> out_pred = nearer index.
//     out_ready low 5 cycles -> outputs stable, in_ready=0.
//  6. Assert reset during ISSUE -> all outputs 0 next edge; next anchor with in_first=0 emits f=w, pred=FFFF.

Source files
------------

// File: rtl/chain_score_sched_pkg.sv
// rtl/chain_score_sched_pkg.sv - shared types and helpers for the chaining-score scheduler
package chain_score_sched_pkg;

    localparam int          SCORE_W  = 32;
    localparam logic [63:0] IDX_NONE = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    // A predecessor only counts if it lies strictly behind on both axes and within reach.
    function automatic logic pair_ok(input logic [SCORE_W-1:0] ri, input logic [SCORE_W-1:0] rj,
                                     input logic [SCORE_W-1:0] qi, input logic [SCORE_W-1:0] qj,
                                     input logic [SCORE_W-1:0] max_dist);
        return (ri > rj) && (qi > qj) && ((ri - rj) <= max_dist);
    endfunction

endpackage

// File: rtl/chain_score_sched_if.sv
// rtl/chain_score_sched_if.sv - anchor, engine and result signals of the scheduler
interface chain_score_sched_if #(
    parameter int IDX_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [31:0]      in_r;
    logic [31:0]      in_q;
    logic [31:0]      in_w;
    logic [31:0]      cfg_w_avg;
    logic [31:0]      cfg_max_dist;
    logic [31:0]      sc_riX;
    logic [31:0]      sc_riY;
    logic [31:0]      sc_qiX;
    logic [31:0]      sc_qiY;
    logic [31:0]      sc_W;
    logic [31:0]      sc_W_avg;
    logic [31:0]      sc_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic [IDX_W-1:0] out_pred;
    logic [IDX_W-1:0] out_idx;

    modport slave (
        input  in_valid, in_first, in_r, in_q, in_w, cfg_w_avg, cfg_max_dist, sc_result, out_ready,
        output in_ready, sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg, out_valid, out_f, out_pred, out_idx
    );

    modport master (
        output in_valid, in_first, in_r, in_q, in_w, cfg_w_avg, cfg_max_dist, sc_result, out_ready,
        input  in_ready, sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg, out_valid, out_f, out_pred, out_idx
    );

endinterface

// File: rtl/chain_tag_pipe.sv
// rtl/chain_tag_pipe.sv - fixed-latency delay line of {valid,live,slot} tags shadowing the score engine
module chain_tag_pipe #(
    parameter int DEPTH  = 9,
    parameter int SLOT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_live,
    input  logic [SLOT_W-1:0] in_slot,
    output logic              out_valid,
    output logic              out_live,
    output logic [SLOT_W-1:0] out_slot,
    output logic              busy
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             live_q, live_d;
    logic [DEPTH-1:0][SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], in_valid};
        live_d  = {live_q[DEPTH-2:0], in_live};
        slot_d  = {slot_q[DEPTH-2:0], in_slot};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            live_q  <= '0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            live_q  <= live_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_live  = live_q[DEPTH-1];
    assign out_slot  = slot_q[DEPTH-1];
    assign busy      = |live_q;

endmodule

// File: rtl/chain_score_sched.sv
// rtl/chain_score_sched.sv - issues predecessor pairs to the score engine and folds f(i)=max(w_i, f(j)+score)
module chain_score_sched
    import chain_score_sched_pkg::*;
#(
    parameter int N         = 16,
    parameter int SCORE_LAT = 9,
    parameter int IDX_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    chain_score_sched_if.slave bus
);

    localparam int               SLOT_W    = $clog2(N);
    localparam int               CNT_W     = SLOT_W + 1;
    localparam logic [IDX_W-1:0] PRED_NONE = IDX_NONE[IDX_W-1:0];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, npairs_q, npairs_d, iss_k_q, iss_k_d;
    logic [SLOT_W-1:0]   wp_q, wp_d;
    logic [IDX_W-1:0]    idx_q, idx_d, cur_idx_q, cur_idx_d, pred_q, pred_d;
    logic [SCORE_W-1:0]  cur_r_q, cur_r_d, cur_q_q, cur_q_d, cur_w_q, cur_w_d, best_q, best_d;
    logic                iss_live_q, iss_live_d, iss_valid_q, iss_valid_d;
    logic [SLOT_W-1:0]   iss_slot_q, iss_slot_d;
    logic [SCORE_W-1:0]  sc_rix_q, sc_rix_d, sc_riy_q, sc_riy_d, sc_qix_q, sc_qix_d;
    logic [SCORE_W-1:0]  sc_qiy_q, sc_qiy_d, sc_w_q, sc_w_d, sc_wavg_q, sc_wavg_d;
    logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [SCORE_W-1:0]  out_f_q, out_f_d;
    logic [IDX_W-1:0]    out_pred_q, out_pred_d, out_idx_q, out_idx_d;
    logic [SCORE_W-1:0]  win_r_q [N], win_r_d [N];
    logic [SCORE_W-1:0]  win_q_q [N], win_q_d [N];
    logic [SCORE_W-1:0]  win_f_q [N], win_f_d [N];
    logic [IDX_W-1:0]    win_idx_q [N], win_idx_d [N];
    logic                tp_valid, tp_live, tp_busy;
    logic [SLOT_W-1:0]   tp_slot, rd_slot;
    logic [SCORE_W-1:0]  cand;

    chain_tag_pipe #(
        .DEPTH  (SCORE_LAT),
        .SLOT_W (SLOT_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (iss_valid_q),
        .in_live   (iss_live_q),
        .in_slot   (iss_slot_q),
        .out_valid (tp_valid),
        .out_live  (tp_live),
        .out_slot  (tp_slot),
        .busy      (tp_busy)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        npairs_d    = npairs_q;
        iss_k_d     = iss_k_q;
        wp_d        = wp_q;
        idx_d       = idx_q;
        cur_idx_d   = cur_idx_q;
        cur_r_d     = cur_r_q;
        cur_q_d     = cur_q_q;
        cur_w_d     = cur_w_q;
        best_d      = best_q;
        pred_d      = pred_q;
        iss_live_d  = 1'b0;
        iss_valid_d = 1'b0;
        iss_slot_d  = iss_slot_q;
        sc_rix_d    = sc_rix_q;
        sc_riy_d    = sc_riy_q;
        sc_qix_d    = sc_qix_q;
        sc_qiy_d    = sc_qiy_q;
        sc_w_d      = sc_w_q;
        sc_wavg_d   = sc_wavg_q;
        out_f_d     = out_f_q;
        out_pred_d  = out_pred_q;
        out_idx_d   = out_idx_q;
        win_r_d     = win_r_q;
        win_q_d     = win_q_q;
        win_f_d     = win_f_q;
        win_idx_d   = win_idx_q;

        // Pairs walk from the newest window entry (wp-1) back toward the oldest.
        rd_slot = wp_q - SLOT_W'(1) - iss_k_q[SLOT_W-1:0];
        cand    = win_f_q[tp_slot] + bus.sc_result;

        // Strict compare: the first (nearest) predecessor wins ties.
        if (tp_live && tp_valid && ($signed(cand) > $signed(best_q))) begin
            best_d = cand;
            pred_d = win_idx_q[tp_slot];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    cur_r_d   = bus.in_r;
                    cur_q_d   = bus.in_q;
                    cur_w_d   = bus.in_w;
                    cur_idx_d = bus.in_first ? '0 : idx_q;
                    cnt_d     = bus.in_first ? '0 : cnt_q;
                    npairs_d  = bus.in_first ? '0 : cnt_q;
                    iss_k_d   = '0;
                    best_d    = bus.in_w;
                    pred_d    = PRED_NONE;
                    state_d   = (npairs_d != '0) ? ST_ISSUE : ST_EMIT;
                end
            end
            ST_ISSUE: begin
                sc_rix_d    = cur_r_q;
                sc_riy_d    = win_r_q[rd_slot];
                sc_qix_d    = cur_q_q;
                sc_qiy_d    = win_q_q[rd_slot];
                sc_w_d      = cur_w_q;
                sc_wavg_d   = bus.cfg_w_avg;
                iss_live_d  = 1'b1;
                iss_valid_d = pair_ok(cur_r_q, win_r_q[rd_slot], cur_q_q, win_q_q[rd_slot],
                                      bus.cfg_max_dist);
                iss_slot_d  = rd_slot;
                iss_k_d     = iss_k_q + CNT_W'(1);
                if (iss_k_q == npairs_q - CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!iss_live_q && !tp_busy) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    win_r_d[wp_q]   = cur_r_q;
                    win_q_d[wp_q]   = cur_q_q;
                    win_f_d[wp_q]   = best_q;
                    win_idx_d[wp_q] = cur_idx_q;
                    wp_d            = wp_q + SLOT_W'(1);
                    cnt_d           = (cnt_q == CNT_W'(N)) ? cnt_q : cnt_q + CNT_W'(1);
                    idx_d           = cur_idx_q + IDX_W'(1);
                    state_d         = ST_IDLE;
                end
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_EMIT);
        if ((state_q != ST_EMIT) && (state_d == ST_EMIT)) begin
            out_f_d    = best_d;
            out_pred_d = pred_d;
            out_idx_d  = cur_idx_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            npairs_q    <= '0;
            iss_k_q     <= '0;
            wp_q        <= '0;
            idx_q       <= '0;
            cur_idx_q   <= '0;
            cur_r_q     <= '0;
            cur_q_q     <= '0;
            cur_w_q     <= '0;
            best_q      <= '0;
            pred_q      <= '0;
            iss_live_q  <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_slot_q  <= '0;
            sc_rix_q    <= '0;
            sc_riy_q    <= '0;
            sc_qix_q    <= '0;
            sc_qiy_q    <= '0;
            sc_w_q      <= '0;
            sc_wavg_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_pred_q  <= '0;
            out_idx_q   <= '0;
            for (int k = 0; k < N; k++) begin
                win_r_q[k]   <= '0;
                win_q_q[k]   <= '0;
                win_f_q[k]   <= '0;
                win_idx_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            npairs_q    <= npairs_d;
            iss_k_q     <= iss_k_d;
            wp_q        <= wp_d;
            idx_q       <= idx_d;
            cur_idx_q   <= cur_idx_d;
            cur_r_q     <= cur_r_d;
            cur_q_q     <= cur_q_d;
            cur_w_q     <= cur_w_d;
            best_q      <= best_d;
            pred_q      <= pred_d;
            iss_live_q  <= iss_live_d;
            iss_valid_q <= iss_valid_d;
            iss_slot_q  <= iss_slot_d;
            sc_rix_q    <= sc_rix_d;
            sc_riy_q    <= sc_riy_d;
            sc_qix_q    <= sc_qix_d;
            sc_qiy_q    <= sc_qiy_d;
            sc_w_q      <= sc_w_d;
            sc_wavg_q   <= sc_wavg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_pred_q  <= out_pred_d;
            out_idx_q   <= out_idx_d;
            win_r_q     <= win_r_d;
            win_q_q     <= win_q_d;
            win_f_q     <= win_f_d;
            win_idx_q   <= win_idx_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sc_riX    = sc_rix_q;
    assign bus.sc_riY    = sc_riy_q;
    assign bus.sc_qiX    = sc_qix_q;
    assign bus.sc_qiY    = sc_qiy_q;
    assign bus.sc_W      = sc_w_q;
    assign bus.sc_W_avg  = sc_wavg_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_f     = out_f_q;
    assign bus.out_pred  = out_pred_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_chain_score_sched.sv
// tb/tb_chain_score_sched.sv - directed checks of the chaining-score scheduler against a fixed-latency engine model
module tb_chain_score_sched;

    localparam int N         = 16;
    localparam int SCORE_LAT = 9;
    localparam int IDX_W     = 16;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   lat;

    logic [31:0] eng_ret;
    logic        ovr_en;
    logic [31:0] ovr_r;
    logic [31:0] ovr_val;
    logic [31:0] eng_pipe [SCORE_LAT];

    chain_score_sched_if #(.IDX_W(IDX_W)) bus ();

    chain_score_sched #(
        .N         (N),
        .SCORE_LAT (SCORE_LAT),
        .IDX_W     (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine: samples sc_* every edge, answers SCORE_LAT edges later.
    always @(posedge clk) begin
        eng_pipe[0] <= (ovr_en && (bus.sc_riY == ovr_r)) ? ovr_val : eng_ret;
        for (int k = 1; k < SCORE_LAT; k++) eng_pipe[k] <= eng_pipe[k-1];
    end
    assign bus.sc_result = eng_pipe[SCORE_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_anchor(input logic first, input logic [31:0] r, input logic [31:0] q,
                              input logic [31:0] w, output int latency);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_r     = r;
        bus.in_q     = q;
        bus.in_w     = w;
        for (int c = 0; c < 50; c++) begin
            if (bus.in_ready) begin
                @(posedge clk); #1;
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        chk("accept", 64'(acc), 64'd1);
        latency = 0;
        while (!bus.out_valid && latency < 100) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic complete();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_first     = 1'b0;
        bus.in_r         = '0;
        bus.in_q         = '0;
        bus.in_w         = '0;
        bus.cfg_w_avg    = 32'd7;
        bus.cfg_max_dist = 32'd1000;
        bus.out_ready    = 1'b0;
        eng_ret = 32'd10;
        ovr_en  = 1'b0;
        ovr_r   = '0;
        ovr_val = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_f", 64'(bus.out_f), 64'd0);
        chk("rst_out_pred", 64'(bus.out_pred), 64'd0);
        chk("rst_sc_riX", 64'(bus.sc_riX), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // First anchor of a read: no predecessors, f = w.
        run_anchor(1'b1, 32'd100, 32'd50, 32'd15, lat);
        chk("t1_lat", 64'(lat), 64'd0);
        chk("t1_f", 64'(bus.out_f), 64'd15);
        chk("t1_pred", 64'(bus.out_pred), 64'hFFFF);
        chk("t1_idx", 64'(bus.out_idx), 64'd0);
        chk("t1_no_issue", 64'(bus.sc_riX), 64'd0);
        complete();

        run_anchor(1'b0, 32'd110, 32'd60, 32'd15, lat);
        chk("t2_lat", 64'(lat), 64'd12);
        chk("t2_riX", 64'(bus.sc_riX), 64'd110);
        chk("t2_riY", 64'(bus.sc_riY), 64'd100);
        chk("t2_W", 64'(bus.sc_W), 64'd15);
        chk("t2_W_avg", 64'(bus.sc_W_avg), 64'd7);
        chk("t2_f", 64'(bus.out_f), 64'd25);
        chk("t2_pred", 64'(bus.out_pred), 64'd0);
        chk("t2_idx", 64'(bus.out_idx), 64'd1);
        complete();

        run_anchor(1'b0, 32'd90, 32'd70, 32'd15, lat);
        chk("t3_lat", 64'(lat), 64'd13);
        chk("t3_riY", 64'(bus.sc_riY), 64'd100);
        chk("t3_f", 64'(bus.out_f), 64'd15);
        chk("t3_pred", 64'(bus.out_pred), 64'hFFFF);
        chk("t3_idx", 64'(bus.out_idx), 64'd2);
        complete();

        // Rising chain longer than the window: f(k)=k+1 via nearest predecessor.
        eng_ret = 32'd1;
        for (int k = 0; k < N + 3; k++) begin
            run_anchor(k == 0, 32'(1000 + 10 * k), 32'(500 + 10 * k), 32'd1, lat);
            chk("t4_lat", 64'(lat), (k == 0) ? 64'd0 : 64'(((k < N) ? k : N) + SCORE_LAT + 2));
            chk("t4_f", 64'(bus.out_f), 64'(k + 1));
            chk("t4_pred", 64'(bus.out_pred), (k == 0) ? 64'hFFFF : 64'(k - 1));
            chk("t4_idx", 64'(bus.out_idx), 64'(k));
            complete();
        end
        chk("t4_oldest_riY", 64'(bus.sc_riY), 64'd1020);

        // Tie between two predecessors: nearer one kept.
        eng_ret = 32'd10;
        run_anchor(1'b1, 32'd10, 32'd10, 32'd20, lat);
        chk("t5a_f", 64'(bus.out_f), 64'd20);
        complete();
        run_anchor(1'b0, 32'd20, 32'd20, 32'd5, lat);
        chk("t5b_f", 64'(bus.out_f), 64'd30);
        chk("t5b_pred", 64'(bus.out_pred), 64'd0);
        complete();
        ovr_en  = 1'b1;
        ovr_r   = 32'd10;
        ovr_val = 32'd20;
        run_anchor(1'b0, 32'd30, 32'd30, 32'd1, lat);
        chk("t5c_lat", 64'(lat), 64'd13);
        chk("t5c_f", 64'(bus.out_f), 64'd40);
        chk("t5c_pred", 64'(bus.out_pred), 64'd1);
        chk("t5c_idx", 64'(bus.out_idx), 64'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t5_hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t5_hold_f", 64'(bus.out_f), 64'd40);
            chk("t5_hold_pred", 64'(bus.out_pred), 64'd1);
        end
        complete();
        ovr_en = 1'b0;

        // Reset while issuing: everything abandoned, window and index restart.
        bus.in_valid = 1'b1;
        bus.in_first = 1'b0;
        bus.in_r     = 32'd100;
        bus.in_q     = 32'd100;
        bus.in_w     = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_issuing", 64'(bus.sc_riX), 64'd100);
        reset = 1'b0;
        #1;
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_sc_riX", 64'(bus.sc_riX), 64'd0);
        chk("t6_sc_riY", 64'(bus.sc_riY), 64'd0);
        chk("t6_out_f", 64'(bus.out_f), 64'd0);
        chk("t6_out_idx", 64'(bus.out_idx), 64'd0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_anchor(1'b0, 32'd5, 32'd5, 32'd9, lat);
        chk("t6_lat", 64'(lat), 64'd0);
        chk("t6_f", 64'(bus.out_f), 64'd9);
        chk("t6_pred", 64'(bus.out_pred), 64'hFFFF);
        chk("t6_idx", 64'(bus.out_idx), 64'd0);
        complete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
